// File: rtl/gat_bram_loader.sv
// Multi-channel host-to-BRAM load engine: routes byte-addressed host beats to per-channel BRAM ports and raises per-channel load_done.
// Optional word-address bounds check against the latched depth is enabled by defining GAT_LOADER_BOUNDS_CHECK_EN.
module gat_bram_loader #(
    parameter int TOP_WIDTH = 32,
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 19,
    parameter int CNT_W     = ADDR_W + 1,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          clear,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic [NUM_CH*CNT_W-1:0]       ch_depth,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic [CH_W-1:0]               host_ch,
    input  logic [TOP_WIDTH-1:0]          host_addr,
    input  logic [TOP_WIDTH-1:0]          host_din,
    output logic [NUM_CH-1:0]             bram_ena,
    output logic [NUM_CH-1:0]             bram_wea,
    output logic [NUM_CH*ADDR_W-1:0]      bram_addr,
    output logic [NUM_CH*TOP_WIDTH-1:0]   bram_din,
    output logic [NUM_CH-1:0]             load_done,
    output logic                          all_done,
    output logic                          err_align,
    output logic                          err_drop,
    output logic                          err_bounds
);

    // state   | meaning
    // IDLE    | waiting for start, host_ready low
    // LOAD    | accepting beats until every enabled channel is done
    // DONE    | all enabled channels loaded, waiting for clear
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;

    state_e                 state_q;
    logic [NUM_CH-1:0]      en_q;
    logic [NUM_CH-1:0]      done_q;
    logic [NUM_CH-1:0]      strobe_q;
    logic [CNT_W-1:0]       depth_q [NUM_CH];
    logic [CNT_W-1:0]       cnt_q   [NUM_CH];
    logic [ADDR_W-1:0]      addr_q  [NUM_CH];
    logic [TOP_WIDTH-1:0]   din_q   [NUM_CH];
    logic                   ready_q;
    logic                   all_done_q;
    logic                   err_align_q;
    logic                   err_drop_q;

    logic                   fire;
    logic                   bad_align;
    logic                   bad_drop;
    logic                   bad_bounds;
    logic                   wr_ok;
    logic                   sel_en;
    logic                   sel_done;
    logic [ADDR_W-1:0]      waddr;
    logic                   unused_addr;

    assign unused_addr = ^host_addr[TOP_WIDTH-1:ADDR_W+2];

`ifdef GAT_LOADER_BOUNDS_CHECK_EN
    localparam int CMP_W = ADDR_W + CNT_W;
    logic [CNT_W-1:0]       sel_depth;
    logic                   err_bounds_q;
`endif

    always_comb begin
        fire      = host_valid && ready_q;
        waddr     = host_addr[ADDR_W+1:2];
        sel_en    = 1'b0;
        sel_done  = 1'b0;
`ifdef GAT_LOADER_BOUNDS_CHECK_EN
        sel_depth = '0;
`endif
        // Channels outside NUM_CH never match, so they fall out as disabled.
        for (int c = 0; c < NUM_CH; c++) begin
            if (32'(host_ch) == c) begin
                sel_en    = en_q[c];
                sel_done  = done_q[c];
`ifdef GAT_LOADER_BOUNDS_CHECK_EN
                sel_depth = depth_q[c];
`endif
            end
        end
        bad_align  = (host_addr[1:0] != 2'b00);
        bad_drop   = !bad_align && (!sel_en || sel_done);
`ifdef GAT_LOADER_BOUNDS_CHECK_EN
        bad_bounds = !bad_align && !bad_drop && (CMP_W'(waddr) >= CMP_W'(sel_depth));
`else
        bad_bounds = 1'b0;
`endif
        wr_ok      = fire && !bad_align && !bad_drop && !bad_bounds;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            en_q        <= '0;
            done_q      <= '0;
            strobe_q    <= '0;
            ready_q     <= 1'b0;
            all_done_q  <= 1'b0;
            err_align_q <= 1'b0;
            err_drop_q  <= 1'b0;
`ifdef GAT_LOADER_BOUNDS_CHECK_EN
            err_bounds_q <= 1'b0;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                depth_q[c] <= '0;
                cnt_q[c]   <= '0;
                addr_q[c]  <= '0;
                din_q[c]   <= '0;
            end
        end else begin
            strobe_q <= '0;
            if (clear) begin
                state_q     <= ST_IDLE;
                ready_q     <= 1'b0;
                all_done_q  <= 1'b0;
                done_q      <= '0;
                err_align_q <= 1'b0;
                err_drop_q  <= 1'b0;
`ifdef GAT_LOADER_BOUNDS_CHECK_EN
                err_bounds_q <= 1'b0;
`endif
                for (int c = 0; c < NUM_CH; c++) begin
                    cnt_q[c] <= '0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q <= ST_LOAD;
                            ready_q <= 1'b1;
                            en_q    <= ch_en;
                            for (int c = 0; c < NUM_CH; c++) begin
                                depth_q[c] <= ch_depth[c*CNT_W +: CNT_W];
                                cnt_q[c]   <= '0;
                                done_q[c]  <= ch_en[c] && (ch_depth[c*CNT_W +: CNT_W] == '0);
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (&(done_q | ~en_q)) begin
                            state_q    <= ST_DONE;
                            ready_q    <= 1'b0;
                            all_done_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b0;
                    end
                endcase

                if (fire) begin
                    if (bad_align) err_align_q <= 1'b1;
                    if (bad_drop)  err_drop_q  <= 1'b1;
`ifdef GAT_LOADER_BOUNDS_CHECK_EN
                    if (bad_bounds) err_bounds_q <= 1'b1;
`endif
                end

                for (int c = 0; c < NUM_CH; c++) begin
                    if (wr_ok && (32'(host_ch) == c)) begin
                        strobe_q[c] <= 1'b1;
                        addr_q[c]   <= waddr;
                        din_q[c]    <= host_din;
                        cnt_q[c]    <= cnt_q[c] + CNT_W'(1);
                        if ((cnt_q[c] + CNT_W'(1)) == depth_q[c]) begin
                            done_q[c] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign bram_addr[g*ADDR_W +: ADDR_W]      = addr_q[g];
        assign bram_din[g*TOP_WIDTH +: TOP_WIDTH] = din_q[g];
    end

    assign bram_ena   = strobe_q;
    assign bram_wea   = strobe_q;
    assign host_ready = ready_q;
    assign load_done  = done_q;
    assign all_done   = all_done_q;
    assign err_align  = err_align_q;
    assign err_drop   = err_drop_q;
`ifdef GAT_LOADER_BOUNDS_CHECK_EN
    assign err_bounds = err_bounds_q;
`else
    assign err_bounds = 1'b0;
`endif

endmodule

// File: tb/tb_gat_bram_loader.sv
// Self-checking bench for gat_bram_loader: expected BRAM writes are queued when beats are driven and popped on each strobe.
module tb_gat_bram_loader;

    localparam int TOP_WIDTH = 32;
    localparam int NUM_CH    = 4;
    localparam int ADDR_W    = 19;
    localparam int CNT_W     = ADDR_W + 1;
    localparam int CH_W      = 2;

    logic                        clk;
    logic                        rst_n;
    logic                        start;
    logic                        clear;
    logic [NUM_CH-1:0]           ch_en;
    logic [NUM_CH*CNT_W-1:0]     ch_depth;
    logic                        host_valid;
    logic                        host_ready;
    logic [CH_W-1:0]             host_ch;
    logic [TOP_WIDTH-1:0]        host_addr;
    logic [TOP_WIDTH-1:0]        host_din;
    logic [NUM_CH-1:0]           bram_ena;
    logic [NUM_CH-1:0]           bram_wea;
    logic [NUM_CH*ADDR_W-1:0]    bram_addr;
    logic [NUM_CH*TOP_WIDTH-1:0] bram_din;
    logic [NUM_CH-1:0]           load_done;
    logic                        all_done;
    logic                        err_align;
    logic                        err_drop;
    logic                        err_bounds;

    gat_bram_loader #(
        .TOP_WIDTH (TOP_WIDTH),
        .NUM_CH    (NUM_CH),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .CH_W      (CH_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clear      (clear),
        .ch_en      (ch_en),
        .ch_depth   (ch_depth),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_ch    (host_ch),
        .host_addr  (host_addr),
        .host_din   (host_din),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .load_done  (load_done),
        .all_done   (all_done),
        .err_align  (err_align),
        .err_drop   (err_drop),
        .err_bounds (err_bounds)
    );

    typedef struct {
        int                   ch;
        logic [ADDR_W-1:0]    addr;
        logic [TOP_WIDTH-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard pop on every BRAM strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bram_ena[c]) begin
                    check_eq("wea_eq_ena", bram_wea[c], 1'b1);
                    if (sb_q.size() == 0) begin
                        check_eq("spurious_strobe", bram_ena[c], 1'b0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check_eq("wr_ch",   c, e.ch);
                        check_eq("wr_addr", bram_addr[c*ADDR_W +: ADDR_W], e.addr);
                        check_eq("wr_data", bram_din[c*TOP_WIDTH +: TOP_WIDTH], e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_start(input logic [NUM_CH-1:0] en, input logic [NUM_CH*CNT_W-1:0] dep);
        ch_en    = en;
        ch_depth = dep;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Drives one beat for one cycle; returns at the negedge of the cycle after acceptance.
    task automatic beat(input int ch, input logic [31:0] addr, input bit wr);
        logic [31:0] d;
        d          = $urandom;
        host_valid = 1'b1;
        host_ch    = CH_W'(ch);
        host_addr  = addr;
        host_din   = d;
        if (wr) sb_q.push_back('{ch, addr[ADDR_W+1:2], d});
        check_eq("ready_at_beat", host_ready, 1'b1);
        @(negedge clk);
        host_valid = 1'b0;
        check_eq("strobe_timing", bram_ena, wr ? (NUM_CH'(1) << ch) : NUM_CH'(0));
    endtask

    function automatic logic [NUM_CH*CNT_W-1:0] pack_dep(input int d0, input int d1, input int d2, input int d3);
        return {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    endfunction

    initial begin
        int seq_ch[11];
        int dep[NUM_CH];
        int cnt[NUM_CH];
        logic [NUM_CH-1:0] exp_done;

        rst_n = 1'b0; start = 1'b0; clear = 1'b0; ch_en = '0; ch_depth = '0;
        host_valid = 1'b0; host_ch = '0; host_addr = '0; host_din = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready",     host_ready, 1'b0);
        check_eq("rst_load_done", load_done,  4'h0);
        check_eq("rst_all_done",  all_done,   1'b0);
        check_eq("rst_errs",      {err_align, err_drop, err_bounds}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", host_ready, 1'b0);

        // Single channel, depth 4, plus a late beat to the now-done channel.
        do_start(4'b0001, pack_dep(4, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_done_before", load_done, 4'h0);
            beat(0, 32'(i * 4), 1'b1);
        end
        check_eq("t1_done_n1", load_done, 4'h1);
        check_eq("t1_all_n1",  all_done,  1'b0);
        beat(0, 32'h10, 1'b0);
        check_eq("t1_all_n2",   all_done,   1'b1);
        check_eq("t1_ready_n2", host_ready, 1'b0);
        check_eq("t1_err_drop", err_drop,   1'b1);
        do_start(4'b0001, pack_dep(4, 0, 0, 0));
        check_eq("t1_start_ignored", all_done, 1'b1);
        do_clear();
        check_eq("t1_clear_errs", {err_align, err_drop, all_done, load_done}, 7'h0);

        // Four channels interleaved back-to-back, depths 3,5,1,2.
        seq_ch = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 1, 1};
        dep    = '{3, 5, 1, 2};
        cnt    = '{0, 0, 0, 0};
        exp_done = '0;
        do_start(4'hF, pack_dep(3, 5, 1, 2));
        for (int i = 0; i < 11; i++) begin
            int c;
            c = seq_ch[i];
            host_valid = 1'b1;
            host_ch    = CH_W'(c);
            host_addr  = 32'(cnt[c] * 4 + 32'h100);
            host_din   = $urandom;
            sb_q.push_back('{c, host_addr[ADDR_W+1:2], host_din});
            cnt[c]++;
            if (cnt[c] == dep[c]) exp_done[c] = 1'b1;
            @(negedge clk);
            check_eq("t2_load_done", load_done, exp_done);
            check_eq("t2_all_pending", all_done, 1'b0);
        end
        host_valid = 1'b0;
        @(negedge clk);
        check_eq("t2_all_done", all_done, 1'b1);
        check_eq("t2_sb_drained", sb_q.size(), 0);
        do_clear();

        // Misaligned and disabled-channel beats are dropped without counting.
        do_start(4'b0011, pack_dep(4, 4, 0, 0));
        beat(0, 32'h6, 1'b0);
        check_eq("t3_err_align", err_align, 1'b1);
        check_eq("t3_no_drop",   err_drop,  1'b0);
        beat(2, 32'h0, 1'b0);
        check_eq("t3_err_drop",  err_drop,  1'b1);
        for (int i = 0; i < 3; i++) beat(0, 32'(i * 4), 1'b1);
        check_eq("t3_count_kept", load_done, 4'h0);
        beat(0, 32'hC, 1'b1);
        check_eq("t3_done", load_done, 4'h1);
        do_clear();

        // Word address beyond depth.
        do_start(4'b0001, pack_dep(2, 0, 0, 0));
`ifdef GAT_LOADER_BOUNDS_CHECK_EN
        beat(0, 32'h8, 1'b0);
        check_eq("t4_err_bounds", err_bounds, 1'b1);
        beat(0, 32'h0, 1'b1);
        check_eq("t4_not_counted", load_done, 4'h0);
        beat(0, 32'h4, 1'b1);
        check_eq("t4_done", load_done, 4'h1);
`else
        beat(0, 32'h8, 1'b1);
        check_eq("t4_err_bounds", err_bounds, 1'b0);
        beat(0, 32'h0, 1'b1);
        check_eq("t4_counted", load_done, 4'h1);
`endif
        do_clear();

        // No enabled channels: LOAD for one cycle then DONE.
        do_start(4'b0000, pack_dep(0, 0, 0, 0));
        check_eq("t5_ready_load", host_ready, 1'b1);
        @(negedge clk);
        check_eq("t5_all_done", all_done, 1'b1);
        do_clear();

        // Clear mid-session, then a fresh session completes.
        do_start(4'b0001, pack_dep(4, 0, 0, 0));
        beat(0, 32'h0, 1'b1);
        beat(0, 32'h4, 1'b1);
        do_clear();
        check_eq("t6_idle_ready", host_ready, 1'b0);
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        check_eq("t6_clear_wins", host_ready, 1'b0);
        do_start(4'b0001, pack_dep(4, 0, 0, 0));
        for (int i = 0; i < 3; i++) beat(0, 32'(i * 4), 1'b1);
        check_eq("t6_restart_cnt", load_done, 4'h0);
        beat(0, 32'hC, 1'b1);
        check_eq("t6_done", load_done, 4'h1);
        @(negedge clk);
        check_eq("t6_all_done", all_done, 1'b1);
        do_clear();

        // Asynchronous reset mid-stream.
        do_start(4'b0011, pack_dep(4, 0, 0, 0));
        beat(0, 32'h0, 1'b1);
        beat(0, 32'h4, 1'b1);
        host_valid = 1'b1;
        host_ch    = 2'd0;
        host_addr  = 32'h8;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t7_rst_ena",   bram_ena,   4'h0);
        check_eq("t7_rst_ready", host_ready, 1'b0);
        check_eq("t7_rst_done",  {load_done, all_done}, 5'h0);
        check_eq("t7_rst_addr",  bram_addr[ADDR_W-1:0], '0);
        check_eq("t7_rst_din",   bram_din[TOP_WIDTH-1:0], '0);
        @(negedge clk);
        host_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t7_idle", host_ready, 1'b0);
        check_eq("t7_no_strobe", bram_ena, 4'h0);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gat_bram_loader.md
# gat_bram_loader

Multi-channel host-to-BRAM load engine for the GAT accelerator. It accepts 32-bit byte-addressed write beats from the PS/AXI side through a valid/ready handshake and routes each beat to one of `NUM_CH` on-chip BRAM write ports. On the way it converts byte addresses to word addresses, rejects bad beats and counts accepted words per channel. It generates the per-channel `*_load_done` flags itself, replacing the software-driven load-done register bits, and sits between the register bank / AXI BRAM controllers and `gat_top`.

## Interface
- `TOP_WIDTH`, 32: host data and byte-address width.
- `NUM_CH`, 4: number of BRAM channels (H data, node info, weight, subgraph).
- `ADDR_W`, 19: word-address width per channel.
- `CNT_W`, `ADDR_W+1`: word-counter and depth width.
- `CH_W`, `$clog2(NUM_CH)`: channel-select width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load session.
- `clear` in 1: abort the session or acknowledge completion; returns to IDLE.
- `ch_en` in `NUM_CH`: channels that take part in the session.
- `ch_depth` in `NUM_CH*CNT_W`: expected word count per channel; channel c uses bits `[c*CNT_W +: CNT_W]`.
- `host_valid` in 1: write beat valid.
- `host_ready` out 1: beat accepted when `host_valid && host_ready`.
- `host_ch` in `CH_W`: target channel.
- `host_addr` in `TOP_WIDTH`: byte address.
- `host_din` in `TOP_WIDTH`: write data.
- `bram_ena` out `NUM_CH`: per-channel enable.
- `bram_wea` out `NUM_CH`: per-channel write enable.
- `bram_addr` out `NUM_CH*ADDR_W`: per-channel word address.
- `bram_din` out `NUM_CH*TOP_WIDTH`: per-channel data.
- `load_done` out `NUM_CH`: channel received `ch_depth` words.
- `all_done` out 1: every enabled channel done.
- `err_align` out 1: sticky; a misaligned beat was dropped.
- `err_drop` out 1: sticky; a beat to a disabled, done or out-of-range channel was dropped.
- `err_bounds` out 1: sticky; a beat beyond `ch_depth` was dropped.

## Operation
- The FSM has three states: IDLE → LOAD → DONE.
- **IDLE**
  - `host_ready`=0.
  - `start` → LOAD. Entering LOAD latches `ch_en` and `ch_depth` and zeroes the counters.
- **LOAD**
  - `host_ready`=1.
  - Moves to DONE when `load_done[c]` is set for every latched-enabled c.
  - `clear` → IDLE (abort).
- **DONE**
  - `host_ready`=0, `all_done`=1.
  - `clear` → IDLE. `start` is ignored.
- An accepted beat is dropped (no BRAM strobe, no count) in these cases:
  - `host_addr[1:0]`≠0: sets `err_align`.
  - `host_ch`≥`NUM_CH`, channel not enabled, or channel already done: sets `err_drop`.
- Word address is `host_addr[ADDR_W+1:2]`.
- A non-dropped beat drives `bram_ena[c]`=`bram_wea[c]`=1 with the word address and data, and increments `cnt[c]`.
- `load_done[c]` sets when `cnt[c]+1 == depth[c]`. Counting is by beats, not unique addresses, so duplicate addresses are counted twice.
- A channel enabled with `depth`=0 has `load_done` set on entry to LOAD. If none of its channels are enabled, the FSM goes LOAD → DONE on the next cycle.
- `clear` zeroes the counters, `load_done`, `all_done` and all error flags.
- If `start` and `clear` are both high in IDLE, `clear` wins and the FSM stays in IDLE.
- Reset values:
  - FSM in IDLE.
  - All outputs 0, including `host_ready`.
  - All counters 0.

## Timing
- A beat accepted in cycle N produces a BRAM strobe, address and data in cycle N+1, registered and held for exactly one cycle. `bram_addr` and `bram_din` hold their last values otherwise.
- `load_done[c]` goes high in cycle N+1 when beat N is the last word.
- `all_done`=1 and `host_ready`=0 from cycle N+2. A beat in N+1 to the done channel is dropped and sets `err_drop`.
- Back-to-back beats sustain one beat per cycle with no bubbles.
- Error flags set in cycle N+1.
- Asserting `rst_n` low mid-session immediately forces the reset values; any in-flight strobe is lost.

## Configuration
- `GAT_LOADER_BOUNDS_CHECK_EN` defined:
  - A beat whose word address is ≥ the latched `depth[c]` is dropped and sets `err_bounds`.
  - Such a beat is not counted.
- Not defined:
  - The word address is truncated to `ADDR_W` and written normally.
  - `err_bounds` is tied 0.

## Test plan
- Single channel, depth=4, words at byte addresses 0x0, 0x4, 0x8, 0xC: the four BRAM writes appear at word addresses 0–3 one cycle after each beat; `load_done[0]` is high in the cycle of the 4th strobe; `all_done`=1 two cycles after the 4th beat; `host_ready`=0.
- Four channels interleaved, depths 3, 5, 1, 2, back-to-back beats: each `load_done` rises independently; `all_done` rises only after the 11th beat; no beat is lost.
- Beat at byte address 0x6: no strobe, `err_align`=1. A beat to a disabled channel: `err_drop`=1. Counts unchanged in both cases.
- With the macro defined, depth=2 and a beat at byte address 0x8: dropped, `err_bounds`=1. Without the macro: written at word 2 and counted.
- `clear` after 2 of 4 words: FSM returns to IDLE, counters zero; a new `start` with 4 beats completes normally.
- `rst_n` pulsed low during a LOAD stream: all outputs are 0 immediately and the FSM is in IDLE.
